tinytone_sequencer: RTL

//  Parametrised successor to the TinyTone sound path: one-voice melody sequencer with built-in PWM tone output.

---
 rtl/tinytone_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tinytone_sequencer.sv
`default_nettype none
// ==========================================================================
// tinytone_sequencer - one-voice ROM-driven melody sequencer with PWM tone out
// Revision: 1.0
// ==========================================================================
module tinytone_sequencer #(
   parameter int PW      = 24,
   parameter int TW      = 24,
   parameter int AW      = 6,
   parameter int SEQ_LEN = 64,
   parameter int GAP_CYC = 0
) (
   input  logic          clk,
   input  logic          rst_n_i,
   input  logic          en_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          loop_i,
   input  logic [TW-1:0] tempo_i,
   input  logic [1:0]    vol_i,
   output logic [AW-1:0] seq_addr_o,
   input  logic [7:0]    seq_data_i,
   output logic [5:0]    note_o,
   input  logic [PW-1:0] period_i,
   output logic          pwm_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int              GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [AW-1:0]   ADDR_LAST = AW'(SEQ_LEN - 1);

   logic [2:0]    state_q,  state_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [5:0]    note_q,   note_d;
   logic [1:0]    dur_q,    dur_d;
   logic [PW-1:0] period_q, period_d;
   logic [PW-1:0] duty_q,   duty_d;
   logic [TW-1:0] tempo_q,  tempo_d;
   logic [TW-1:0] beat_q,   beat_d;
   logic [2:0]    bidx_q,   bidx_d;
   logic [PW-1:0] pc_q,     pc_d;
   logic [GW-1:0] gap_q,    gap_d;
   logic          rest_q,   rest_d;
   logic          pwm_q,    pwm_d;

   logic          w_adv, w_eos, w_beat_wrap, w_play_end, w_rest;
   logic [2:0]    w_idx_last;
   logic [PW-1:0] w_duty, w_pc_next;

   always_comb begin
      case (dur_q)
         2'd0:    w_idx_last = 3'd0;
         2'd1:    w_idx_last = 3'd1;
         2'd2:    w_idx_last = 3'd3;
         default: w_idx_last = 3'd7;
      endcase
   end

   assign w_duty      = period_i >> (32'd1 + 32'(vol_i));
   assign w_rest      = (note_q == 6'd0) || (period_i < PW'(2)) || (w_duty == '0);
   assign w_beat_wrap = (beat_q == tempo_q - TW'(1));
   assign w_play_end  = w_beat_wrap && (bidx_q == w_idx_last);
   assign w_pc_next   = (pc_q == period_q - PW'(1)) ? '0 : pc_q + PW'(1);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      note_d   = note_q;
      dur_d    = dur_q;
      period_d = period_q;
      duty_d   = duty_q;
      tempo_d  = tempo_q;
      beat_d   = beat_q;
      bidx_d   = bidx_q;
      pc_d     = pc_q;
      gap_d    = gap_q;
      rest_d   = rest_q;
      pwm_d    = pwm_q;
      w_adv    = 1'b0;
      w_eos    = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (seq_data_i == 8'hFF) begin
               w_eos = 1'b1;
            end else begin
               dur_d   = seq_data_i[7:6];
               note_d  = seq_data_i[5:0];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            period_d = period_i;
            duty_d   = w_duty;
            tempo_d  = (tempo_i == '0) ? TW'(1) : tempo_i;
            beat_d   = '0;
            bidx_d   = '0;
            pc_d     = '0;
            rest_d   = w_rest;
            pwm_d    = !w_rest;
            state_d  = S_PLAY;
         end
         S_PLAY: begin
            if (w_play_end) begin
               pwm_d = 1'b0;
               if (GAP_CYC > 0) begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  w_adv = 1'b1;
               end
            end else begin
               if (w_beat_wrap) begin
                  beat_d = '0;
                  bidx_d = bidx_q + 3'd1;
               end else begin
                  beat_d = beat_q + TW'(1);
               end
               pc_d  = w_pc_next;
               pwm_d = !rest_q && (w_pc_next < duty_q);
            end
         end
         S_GAP: begin
            pwm_d = 1'b0;
            if (gap_q == GAP_LAST) begin
               w_adv = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: ;
      endcase

      if (w_adv) begin
         if (addr_q == ADDR_LAST) begin
            w_eos = 1'b1;
         end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_FETCH;
         end
      end

      if (w_eos) begin
         pwm_d = 1'b0;
         if (loop_i) begin
            addr_d  = '0;
            state_d = S_FETCH;
         end else begin
            state_d = S_DONE;
         end
      end

      // stop outranks start; a stopped sequencer keeps its address
      if (start_i) begin
         addr_d  = '0;
         pwm_d   = 1'b0;
         state_d = S_FETCH;
      end
      if (stop_i) begin
         addr_d  = addr_q;
         pwm_d   = 1'b0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         note_q   <= '0;
         dur_q    <= '0;
         period_q <= '0;
         duty_q   <= '0;
         tempo_q  <= '0;
         beat_q   <= '0;
         bidx_q   <= '0;
         pc_q     <= '0;
         gap_q    <= '0;
         rest_q   <= 1'b0;
         pwm_q    <= 1'b0;
      end else if (en_i) begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         note_q   <= note_d;
         dur_q    <= dur_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         tempo_q  <= tempo_d;
         beat_q   <= beat_d;
         bidx_q   <= bidx_d;
         pc_q     <= pc_d;
         gap_q    <= gap_d;
         rest_q   <= rest_d;
         pwm_q    <= pwm_d;
      end
   end

   assign seq_addr_o = addr_q;
   assign note_o     = note_q;
   assign pwm_o      = pwm_q;
   assign busy_o     = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                       (state_q == S_PLAY)  || (state_q == S_GAP);
   assign done_o     = (state_q == S_DONE);

endmodule
`default_nettype wire
